// File: rtl/serial_negate_ctrl_if.sv
// Operand/result handshake bundle for serial_negate_ctrl.
// Ports: in_valid/in_ready/in_data, out_valid/out_ready/out_data.
interface serial_negate_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/serial_negate_ctrl.sv
// Serial two's-complement negator, one bit per clock, LSB first.
// Ports: clk, areset (async, active-high), bus (slave), busy, ovf.
// Optional: define SNEG_OVF_FLAG_EN to add the ovf output.
module serial_negate_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  areset,
  serial_negate_ctrl_if.slave   bus,
`ifdef SNEG_OVF_FLAG_EN
  output logic                  ovf,
`endif
  output logic                  busy
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             seen_q, seen_d;
  logic             rbit;
`ifdef SNEG_OVF_FLAG_EN
  logic             ovf_q, ovf_d;
`endif

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q <= IDLE;
      sh_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      seen_q  <= 1'b0;
`ifdef SNEG_OVF_FLAG_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      seen_q  <= seen_d;
`ifdef SNEG_OVF_FLAG_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Bits below the first 1 pass through; every bit after it inverts.
  assign rbit = sh_q[0] ^ seen_q;

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    seen_d  = seen_q;
`ifdef SNEG_OVF_FLAG_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = SHIFT;
          sh_d    = bus.in_data;
          res_d   = '0;
          cnt_d   = '0;
          seen_d  = 1'b0;
`ifdef SNEG_OVF_FLAG_EN
          ovf_d   = (bus.in_data == MIN_NEG);
`endif
        end
      end
      SHIFT: begin
        sh_d   = {1'b0, sh_q[WIDTH-1:1]};
        res_d  = {rbit, res_q[WIDTH-1:1]};
        seen_d = seen_q | sh_q[0];
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            // Result leaves and next operand lands on the same edge.
            state_d = SHIFT;
            sh_d    = bus.in_data;
            res_d   = '0;
            cnt_d   = '0;
            seen_d  = 1'b0;
`ifdef SNEG_OVF_FLAG_EN
            ovf_d   = (bus.in_data == MIN_NEG);
`endif
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy          = (state_q != IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = (state_q == DONE) ? res_q : '0;
  assign bus.in_ready  = (state_q == IDLE) |
                         ((state_q == DONE) & bus.out_ready);
`ifdef SNEG_OVF_FLAG_EN
  assign ovf           = (state_q == DONE) & ovf_q;
`endif

endmodule

// File: tb/tb_serial_negate_ctrl.sv
// Self-checking bench for serial_negate_ctrl, WIDTH=8.
// Random and directed operands against an arithmetic model.
module tb_serial_negate_ctrl;

  localparam int W = 8;

  logic clk;
  logic areset;
  logic busy;
`ifdef SNEG_OVF_FLAG_EN
  logic ovf;
`endif

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  serial_negate_ctrl_if #(.WIDTH(W)) bus ();

  serial_negate_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .areset (areset),
    .bus    (bus.slave),
`ifdef SNEG_OVF_FLAG_EN
    .ovf    (ovf),
`endif
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic logic [W-1:0] model_neg(input logic [W-1:0] x);
    int unsigned v;
    v = (256 - int'(x)) % 256;
    return v[W-1:0];
  endfunction

  task automatic test_reset();
    areset        = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    #12;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
        busy !== 1'b0 || bus.out_data !== 8'h00) begin
      errors++;
      $display("FAIL reset: rdy=%b vld=%b busy=%b data=%h want 1 0 0 00",
               bus.in_ready, bus.out_valid, busy, bus.out_data);
    end
    @(negedge clk);
    areset = 1'b0;
  endtask

  task automatic do_op(input logic [W-1:0] x);
    logic [W-1:0] exp;
    int lat;
    bit to;
    exp = model_neg(x);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL op_ready %h: in_ready=%b want 1", x, bus.in_ready);
    end
    bus.in_valid  = 1'b1;
    bus.in_data   = x;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = $urandom;
    lat = 0;
    to  = 1'b0;
    while (bus.out_valid !== 1'b1) begin
      checks++;
      if (busy !== 1'b1 || bus.in_ready !== 1'b0 ||
          bus.out_data !== 8'h00) begin
        errors++;
        $display("FAIL op_shift %h: busy=%b rdy=%b data=%h want 1 0 00",
                 x, busy, bus.in_ready, bus.out_data);
      end
      @(negedge clk);
      lat++;
      if (lat > 40) begin
        to = 1'b1;
        break;
      end
    end
    checks++;
    if (to) begin
      errors++;
      $display("FAIL op_timeout %h: no out_valid after %0d edges", x, lat);
    end else begin
      if (lat != W) begin
        errors++;
        $display("FAIL op_latency %h: %0d edges want %0d", x, lat, W);
      end
      checks++;
      if (bus.out_data !== exp || bus.in_ready !== 1'b1 || busy !== 1'b1) begin
        errors++;
        $display("FAIL op_data %h: data=%h rdy=%b busy=%b want %h 1 1",
                 x, bus.out_data, bus.in_ready, busy, exp);
      end
`ifdef SNEG_OVF_FLAG_EN
      checks++;
      if (ovf !== (x == 8'h80)) begin
        errors++;
        $display("FAIL op_ovf %h: ovf=%b want %b", x, ovf, (x == 8'h80));
      end
`endif
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.out_data !== 8'h00) begin
      errors++;
      $display("FAIL op_idle %h: vld=%b busy=%b data=%h want 0 0 00",
               x, bus.out_valid, busy, bus.out_data);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] v [6];
    v = '{8'h05, 8'h00, 8'h01, 8'hFF, 8'h80, 8'h7F};
    foreach (v[i]) do_op(v[i]);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      do_op(W'($urandom));
    end
  endtask

  task automatic test_stall();
    int n;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h10;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_data = 8'h33;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== model_neg(8'h10) ||
          bus.in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL stall %0d: vld=%b data=%h rdy=%b busy=%b want 1 %h 0 1",
                 k, bus.out_valid, bus.out_data, bus.in_ready, busy,
                 model_neg(8'h10));
      end
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: vld=%b busy=%b want 0 0",
               bus.out_valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ops [2];
    int t [2];
    logic [W-1:0] got [2];
    int n;
    ops = '{8'h03, 8'h0A};
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = ops[0];
    @(negedge clk);
    bus.in_data = ops[1];
    for (int r = 0; r < 2; r++) begin
      n = 0;
      while (bus.out_valid !== 1'b1 && n < 40) begin
        @(negedge clk);
        n++;
      end
      t[r]   = edge_cnt;
      got[r] = bus.out_data;
      @(negedge clk);
      bus.in_valid = 1'b0;
      checks++;
      if (got[r] !== model_neg(ops[r])) begin
        errors++;
        $display("FAIL b2b_data %0d: %h want %h", r, got[r], model_neg(ops[r]));
      end
    end
    checks++;
    if (t[1] - t[0] != W + 1) begin
      errors++;
      $display("FAIL b2b_spacing: %0d edges want %0d", t[1] - t[0], W + 1);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h55;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 areset = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
        busy !== 1'b0 || bus.out_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid: rdy=%b vld=%b busy=%b data=%h want 1 0 0 00",
               bus.in_ready, bus.out_valid, busy, bus.out_data);
    end
`ifdef SNEG_OVF_FLAG_EN
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf: ovf=%b want 0", ovf);
    end
`endif
    @(negedge clk);
    areset = 1'b0;
    do_op(8'h02);
  endtask

  initial begin
    test_reset();
    do_op(8'h05);
    test_directed();
    test_random();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
